// File: rtl/mux8by1_pkg.sv
// Shared constants and types for the registered 8-to-1 lane selector.
// Imported by mux8by1_lane_sel and mux_8by1.
package mux8by1_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux8by1_pkg

// File: rtl/mux8by1_lane_sel.sv
// Purely combinational selector: picks lane s out of NUM_IN packed lanes.
// Lane k occupies i[k*DATA_W +: DATA_W].
module mux8by1_lane_sel
  import mux8by1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_IN*DATA_W-1:0] i,
  input  sel_t                     s,
  output logic [DATA_W-1:0]        lane
);

  // Every select code maps to a lane, so the default is never the final value.
  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (s == sel_t'(k)) begin
        lane = i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule : mux8by1_lane_sel

// File: rtl/mux_8by1.sv
// Registered 8-to-1 multiplexer: one-cycle latency from i/s to Y, sync active-low reset.
// Optional MUX8BY1_PARITY_EN adds Y_par, the registered XOR-reduction of the selected lane.
module mux_8by1
  import mux8by1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] i,
  input  sel_t                     s,
  output logic [DATA_W-1:0]        Y
`ifdef MUX8BY1_PARITY_EN
  ,
  output logic                     Y_par
`endif
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] y_d;
  logic [DATA_W-1:0] y_q;

  mux8by1_lane_sel #(
    .DATA_W (DATA_W)
  ) u_lane_sel (
    .i    (i),
    .s    (s),
    .lane (lane)
  );

  always_comb begin
    y_d = lane;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

`ifdef MUX8BY1_PARITY_EN
  logic par_d;
  logic par_q;

  always_comb begin
    par_d = ^lane;
  end

  // Same edge and reset as y_q so Y and Y_par always describe the same lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign Y_par = par_q;
`endif

endmodule : mux_8by1

// File: tb/tb_mux_8by1.sv
// Directed and random checks of mux_8by1 at DATA_W=1 and DATA_W=4.
// Parity output is checked when MUX8BY1_PARITY_EN is defined.
module tb_mux_8by1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i1;
  logic [31:0] i4;
  logic [2:0]  s;
  logic [0:0]  y1;
  logic [3:0]  y4;
`ifdef MUX8BY1_PARITY_EN
  logic        y1_par;
  logic        y4_par;
`endif

  logic [0:0] exp1_q[$];
  logic [3:0] exp4_q[$];
  logic [0:0] par1_q[$];
  logic [0:0] par4_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_8by1 #(.DATA_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i1),
    .s     (s),
    .Y     (y1)
`ifdef MUX8BY1_PARITY_EN
    ,
    .Y_par (y1_par)
`endif
  );

  mux_8by1 #(.DATA_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i4),
    .s     (s),
    .Y     (y4)
`ifdef MUX8BY1_PARITY_EN
    ,
    .Y_par (y4_par)
`endif
  );

  task automatic check1(input string tag, input logic [0:0] obs);
    logic [0:0] exp;
    total_cnt++;
    if (exp1_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
      return;
    end
    exp = exp1_q.pop_front();
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs);
    logic [3:0] exp;
    total_cnt++;
    if (exp4_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
      return;
    end
    exp = exp4_q.pop_front();
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef MUX8BY1_PARITY_EN
  task automatic check_par(input string tag, input logic obs, input logic [0:0] exp);
    total_cnt++;
    assert (obs === exp[0]) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp[0]);
    end
  endtask
`endif

  // Driver: apply inputs at negedge, push expectations, compare 1 ns after the next posedge.
  task automatic step(input string tag, input logic rn, input logic [7:0] iv,
                      input logic [31:0] iv4, input logic [2:0] sv);
    logic [0:0] e1;
    logic [3:0] e4;
    @(negedge clk);
    rst_n = rn;
    i1    = iv;
    i4    = iv4;
    s     = sv;
    e1    = rn ? iv[sv] : 1'b0;
    e4    = rn ? iv4[sv*4 +: 4] : 4'h0;
    exp1_q.push_back(e1);
    exp4_q.push_back(e4);
    par1_q.push_back(e1);
    par4_q.push_back(^e4);
    @(posedge clk);
    #1;
    check1({tag, "_y1"}, y1);
    check4({tag, "_y4"}, y4);
`ifdef MUX8BY1_PARITY_EN
    check_par({tag, "_par1"}, y1_par, par1_q.pop_front());
    check_par({tag, "_par4"}, y4_par, par4_q.pop_front());
`else
    void'(par1_q.pop_front());
    void'(par4_q.pop_front());
`endif
  endtask

  localparam logic [31:0] RAMP = 32'h7654_3210;

  initial begin
    logic [7:0] onehot;
    rst_n = 1'b0;
    i1    = 8'h00;
    i4    = 32'h0;
    s     = 3'd0;

    // Reset held for two edges, then release captures lane 5
    step("rst_hold0", 1'b0, 8'hFF, 32'hFFFF_FFFF, 3'd5);
    step("rst_hold1", 1'b0, 8'hFF, 32'hFFFF_FFFF, 3'd5);
    step("rst_rel",   1'b1, 8'hFF, 32'hFFFF_FFFF, 3'd5);

    // Walking one, then clearing the selected bit
    for (int k = 0; k < 8; k++) begin
      onehot = 8'h01 << k;
      step("walk1_set", 1'b1, onehot, RAMP, 3'(k));
      step("walk1_clr", 1'b1, 8'h00, 32'h0, 3'(k));
    end

    // Unselected lanes toggling must not disturb Y
    step("unsel_a", 1'b1, 8'b0000_0100, RAMP, 3'd2);
    step("unsel_b", 1'b1, 8'b1111_1111, 32'hFFFF_F2FF, 3'd2);
    step("unsel_c", 1'b1, 8'b0000_0100, RAMP, 3'd2);

    // Walking zero and all-zero input
    for (int k = 0; k < 8; k++) begin
      onehot = 8'h01 << k;
      step("walk0", 1'b1, ~onehot, ~RAMP, 3'(k));
    end
    for (int k = 0; k < 8; k++) begin
      step("all_zero", 1'b1, 8'h00, 32'h0, 3'(k));
    end

    // Mid-stream reset pulse
    step("mid_set", 1'b1, 8'h80, RAMP, 3'd7);
    step("mid_rst", 1'b0, 8'h80, RAMP, 3'd7);
    step("mid_rel", 1'b1, 8'h80, RAMP, 3'd7);

    // Wide lanes: lane k holds k; s=6 gives 6 (parity 0), s=7 gives 7 (parity 1)
    step("wide_s6", 1'b1, 8'h40, RAMP, 3'd6);
    step("wide_s7", 1'b1, 8'h80, RAMP, 3'd7);

    // Random stimulus with occasional reset, s and i changing together
    for (int n = 0; n < 40; n++) begin
      step("rand", ($urandom_range(0, 7) != 0), 8'($urandom_range(0, 255)),
           $urandom, 3'($urandom_range(0, 7)));
    end

    total_cnt++;
    assert (exp1_q.size() == 0 && exp4_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $error("FAIL sb_drain: observed %0d/%0d left expected 0/0",
             exp1_q.size(), exp4_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_mux_8by1
